proc_ctrl_seq: RTL and testbench

Parametrised multi-cycle control sequencer for the simple processor datapath. Accepts one instruction per start handshake (function code plus two register indices) and steps through registered control states, driving one-hot register-file enables, bus-drive and ALU control (Rh/Rl staging registers, add/sub, logic unit). It generalises the processor's original controller:
- register count is a parameter;
- a fourth ALU function (AND) is added;
- start/busy/done handshake with back-to-back issue;
- illegal-instruction detection;
- asynchronous reset.

---
 rtl/proc_ctrl_seq_if.sv | 36 +++
 rtl/proc_ctrl_seq.sv | 99 +++++++++
 tb/tb_proc_ctrl_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_ctrl_seq_if.sv
// proc_ctrl_seq_if: instruction handshake plus datapath control bundle for the control sequencer.
interface proc_ctrl_seq_if #(
    parameter int NREG = 4,
    parameter int IDXW = 3
);
    logic            start;
    logic [3:0]      func;
    logic [IDXW-1:0] rx;
    logic [IDXW-1:0] ry;
    logic            ready;
    logic            busy;
    logic            done;
    logic            err;
    logic            data_out;
    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;
    logic            add_sub;
    logic            rh_in;
    logic            rl_in;
    logic            rl_out;
    logic            as_enable;
    logic            logic_enable;
    logic [1:0]      alu_sel;

    modport master (
        output start, func, rx, ry,
        input  ready, busy, done, err, data_out, r_in, r_out, add_sub,
               rh_in, rl_in, rl_out, as_enable, logic_enable, alu_sel
    );

    modport slave (
        input  start, func, rx, ry,
        output ready, busy, done, err, data_out, r_in, r_out, add_sub,
               rh_in, rl_in, rl_out, as_enable, logic_enable, alu_sel
    );
endinterface

// File: rtl/proc_ctrl_seq.sv
// proc_ctrl_seq: multi-cycle control sequencer; every output is a flop loaded from the next-state decode.
module proc_ctrl_seq #(
    parameter int NREG = 4,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    proc_ctrl_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LD, MV, OPA, OPB, WB, ERR} state_t;

    state_t          state_q, state_d;
    logic [3:0]      func_q, func_d;
    logic [IDXW-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [NREG-1:0] ohx_d, ohy_d, rin_q, rout_q;
    logic            ready_q, busy_q, done_q, err_q, dout_q;
    logic            add_sub_q, rh_q, rl_q, rlo_q, as_q, le_q;
    logic [1:0]      sel_q;
    logic            accept, bad, alu_d;

    assign accept = bus.start && ready_q;
    assign bad    = !(bus.func inside {[4'd1:4'd6]}) || int'(bus.rx) >= NREG ||
                    (bus.func != 4'd1 && int'(bus.ry) >= NREG);

    always_comb begin
        func_d  = func_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        state_d = state_q == OPA ? OPB : state_q == OPB ? WB : IDLE;
        if (accept) begin
            func_d  = bus.func;
            rx_d    = bus.rx;
            ry_d    = bus.ry;
            state_d = bad ? ERR : bus.func == 4'd1 ? LD : bus.func == 4'd2 ? MV : OPA;
        end
    end

    assign ohx_d = NREG'(1) << rx_d;
    assign ohy_d = NREG'(1) << ry_d;
    assign alu_d = state_d inside {OPA, OPB, WB};

    // Outputs are loaded from the upcoming state so they stay pure flops with no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            func_q    <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= 1'b0;
            rin_q     <= '0;
            rout_q    <= '0;
            add_sub_q <= 1'b0;
            rh_q      <= 1'b0;
            rl_q      <= 1'b0;
            rlo_q     <= 1'b0;
            as_q      <= 1'b0;
            le_q      <= 1'b0;
            sel_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            ready_q   <= state_d inside {IDLE, LD, MV, WB};
            busy_q    <= state_d != IDLE;
            done_q    <= state_d inside {LD, MV, WB};
            err_q     <= state_d == ERR;
            dout_q    <= state_d == LD;
            rin_q     <= state_d inside {LD, MV, WB} ? ohx_d : '0;
            rout_q    <= state_d inside {MV, OPB} ? ohy_d : state_d == OPA ? ohx_d : '0;
            rh_q      <= state_d == OPA;
            rl_q      <= state_d == OPB;
            rlo_q     <= state_d == WB;
            add_sub_q <= alu_d && func_d == 4'd4;
            as_q      <= alu_d && func_d inside {4'd3, 4'd4};
            le_q      <= alu_d && func_d inside {4'd5, 4'd6};
            sel_q     <= alu_d ? {func_d inside {4'd5, 4'd6}, func_d inside {4'd4, 4'd6}} : 2'b00;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.data_out     = dout_q;
    assign bus.r_in         = rin_q;
    assign bus.r_out        = rout_q;
    assign bus.add_sub      = add_sub_q;
    assign bus.rh_in        = rh_q;
    assign bus.rl_in        = rl_q;
    assign bus.rl_out       = rlo_q;
    assign bus.as_enable    = as_q;
    assign bus.logic_enable = le_q;
    assign bus.alu_sel      = sel_q;
endmodule

// File: tb/tb_proc_ctrl_seq.sv
// tb_proc_ctrl_seq: three sequencers (NREG 4/6/8) checked each cycle against a queue-of-expected-cycles model.
module tb_proc_ctrl_seq;
    typedef logic [28:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       st[3];
    logic [3:0] fn[3];
    logic [2:0] xs[3];
    logic [2:0] ys[3];
    vec_t       dv[3];
    vec_t       q[3][$];
    int         nr[3] = '{4, 6, 8};

    logic [3:0] tf[7] = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd0, 4'd15, 4'd2};
    logic [2:0] tx[7] = '{3'd0, 3'd0, 3'd5, 3'd7, 3'd0, 3'd1, 3'd3};
    logic [2:0] ty[7] = '{3'd7, 3'd5, 3'd5, 3'd2, 3'd0, 3'd1, 3'd7};
    logic [3:0] sf[12] = '{4'd2, 4'd3, 4'd9, 4'd1, 4'd6, 4'd5, 4'd2, 4'd4, 4'd1, 4'd0, 4'd3, 4'd2};
    logic [2:0] sx[12] = '{3'd7, 3'd1, 3'd2, 3'd4, 3'd6, 3'd0, 3'd3, 3'd5, 3'd2, 3'd1, 3'd7, 3'd0};
    logic [2:0] sy[12] = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd7, 3'd1, 3'd3, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6};

    always #5 clk = ~clk;

    proc_ctrl_seq_if #(.NREG(4), .IDXW(3)) i4 ();
    proc_ctrl_seq_if #(.NREG(6), .IDXW(3)) i6 ();
    proc_ctrl_seq_if #(.NREG(8), .IDXW(3)) i8 ();

    proc_ctrl_seq #(.NREG(4), .IDXW(3)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    proc_ctrl_seq #(.NREG(6), .IDXW(3)) u6 (.clk(clk), .rst_n(rst_n), .bus(i6));
    proc_ctrl_seq #(.NREG(8), .IDXW(3)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));

    assign i4.start = st[0];
    assign i4.func  = fn[0];
    assign i4.rx    = xs[0];
    assign i4.ry    = ys[0];
    assign i6.start = st[1];
    assign i6.func  = fn[1];
    assign i6.rx    = xs[1];
    assign i6.ry    = ys[1];
    assign i8.start = st[2];
    assign i8.func  = fn[2];
    assign i8.rx    = xs[2];
    assign i8.ry    = ys[2];

    assign dv[0] = {i4.ready, i4.busy, i4.done, i4.err, i4.data_out, i4.add_sub, i4.rh_in, i4.rl_in,
                    i4.rl_out, i4.as_enable, i4.logic_enable, i4.alu_sel, 8'(i4.r_in), 8'(i4.r_out)};
    assign dv[1] = {i6.ready, i6.busy, i6.done, i6.err, i6.data_out, i6.add_sub, i6.rh_in, i6.rl_in,
                    i6.rl_out, i6.as_enable, i6.logic_enable, i6.alu_sel, 8'(i6.r_in), 8'(i6.r_out)};
    assign dv[2] = {i8.ready, i8.busy, i8.done, i8.err, i8.data_out, i8.add_sub, i8.rh_in, i8.rl_in,
                    i8.rl_out, i8.as_enable, i8.logic_enable, i8.alu_sel, 8'(i8.r_in), 8'(i8.r_out)};

    // Flag order: ready busy done err data_out add_sub rh_in rl_in rl_out as_enable logic_enable.
    function automatic vec_t mk(logic [10:0] fl, logic [1:0] sel, logic [7:0] ri, logic [7:0] ro);
        return {fl, sel, ri, ro};
    endfunction

    localparam vec_t IDLE_V = {11'b10000000000, 2'b00, 8'h00, 8'h00};

    function automatic void push(int k, logic [3:0] f, logic [2:0] x, logic [2:0] y);
        logic [7:0] ox, oy;
        logic [1:0] s;
        logic       sb, a, l;
        ox = 8'd1 << x;
        oy = 8'd1 << y;
        s  = f == 4'd3 ? 2'd0 : f == 4'd4 ? 2'd1 : f == 4'd5 ? 2'd2 : 2'd3;
        sb = f == 4'd4;
        a  = f == 4'd3 || f == 4'd4;
        l  = f == 4'd5 || f == 4'd6;
        if (f < 4'd1 || f > 4'd6 || int'(x) >= nr[k] || (f != 4'd1 && int'(y) >= nr[k]))
            q[k].push_back(mk(11'b01010000000, 2'b00, 8'h00, 8'h00));
        else if (f == 4'd1)
            q[k].push_back(mk(11'b11101000000, 2'b00, ox, 8'h00));
        else if (f == 4'd2)
            q[k].push_back(mk(11'b11100000000, 2'b00, ox, oy));
        else begin
            q[k].push_back(mk({5'b01000, sb, 3'b100, a, l}, s, 8'h00, ox));
            q[k].push_back(mk({5'b01000, sb, 3'b010, a, l}, s, 8'h00, oy));
            q[k].push_back(mk({5'b11100, sb, 3'b001, a, l}, s, ox, 8'h00));
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) q[k].delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                vec_t cur;
                cur = q[k].size() != 0 ? q[k].pop_front() : IDLE_V;
                if (st[k] && cur[28]) push(k, fn[k], xs[k], ys[k]);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            vec_t e;
            e = q[k].size() != 0 ? q[k][0] : IDLE_V;
            checks++;
            if (dv[k] !== e) begin
                errors++;
                $display("FAIL model[NREG=%0d] t=%0t: got %h expected %h", nr[k], $time, dv[k], e);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic issue(int k, logic [3:0] f, logic [2:0] x, logic [2:0] y);
        @(negedge clk);
        st[k] = 1'b1;
        fn[k] = f;
        xs[k] = x;
        ys[k] = y;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            fn[k] = 4'd0;
            xs[k] = 3'd0;
            ys[k] = 3'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", i4.ready, 1);
        chk("rst_busy", i4.busy, 0);
        chk("rst_en", {i4.r_in, i4.r_out, i4.data_out, i4.rh_in, i4.rl_in, i4.rl_out}, 0);
        #2 rst_n = 1'b1;
        issue(0, 4'd1, 3'd2, 3'd0);
        chk("ld_dout", i4.data_out, 1);
        chk("ld_rin", i4.r_in, 4'b0100);
        chk("ld_done", i4.done, 1);
        issue(0, 4'd3, 3'd1, 3'd3);
        chk("add1_rout", i4.r_out, 4'b0010);
        chk("add1_rh", i4.rh_in, 1);
        chk("add1_alu", {i4.alu_sel, i4.as_enable}, 3'b001);
        @(negedge clk);
        chk("add2_rout", i4.r_out, 4'b1000);
        chk("add2_rl", i4.rl_in, 1);
        @(negedge clk);
        chk("add3_ctl", {i4.rl_out, i4.done}, 2'b11);
        chk("add3_rin", i4.r_in, 4'b0010);
        chk("add3_alu", {i4.alu_sel, i4.as_enable}, 3'b001);
        @(negedge clk);
        st[0] = 1'b1; fn[0] = 4'd4; xs[0] = 3'd0; ys[0] = 3'd1;
        @(negedge clk);
        fn[0] = 4'd6; xs[0] = 3'd2; ys[0] = 3'd3;
        chk("sub1_rout", i4.r_out, 4'b0001);
        @(negedge clk);
        chk("sub2_rout", i4.r_out, 4'b0010);
        @(negedge clk);
        chk("sub3_done", {i4.done, i4.ready, i4.add_sub, i4.alu_sel}, 5'b11101);
        @(negedge clk);
        st[0] = 1'b0;
        chk("b2b_and_opa", {i4.rh_in, i4.alu_sel, i4.logic_enable, i4.as_enable}, 5'b11110);
        chk("b2b_and_rout", i4.r_out, 4'b0100);
        repeat (2) @(negedge clk);
        issue(0, 4'd7, 3'd0, 3'd0);
        chk("ill_err", {i4.err, i4.ready, i4.busy}, 3'b101);
        chk("ill_en", {i4.r_in, i4.r_out}, 0);
        @(negedge clk);
        chk("ill_ready", {i4.ready, i4.err}, 2'b10);
        issue(1, 4'd2, 3'd6, 3'd0);
        chk("mv6_err", i6.err, 1);
        chk("mv6_rin", i6.r_in, 0);
        issue(1, 4'd2, 3'd5, 3'd5);
        chk("mv6_self", {i6.r_in, i6.r_out, i6.done}, 13'b1000001000001);
        issue(0, 4'd5, 3'd1, 3'd2);
        @(negedge clk);
        chk("xor_opb", {i4.rl_in, i4.r_out, i4.alu_sel}, 7'b1010010);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", {i4.r_out, i4.rl_in, i4.done, i4.busy, i4.ready}, 8'b00000001);
        repeat (2) @(negedge clk);
        chk("rst_mid_nodone", {i4.done, i4.err}, 0);
        #2 rst_n = 1'b1;
        issue(0, 4'd1, 3'd3, 3'd0);
        chk("ld2", {i4.data_out, i4.r_in, i4.done}, 6'b110001);
        issue(2, 4'd2, 3'd7, 3'd0);
        chk("mv8_rout", i8.r_out, 8'b00000001);
        chk("mv8_rin", i8.r_in, 8'b10000000);
        chk("mv8_done", i8.done, 1);
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 3; k++) begin
                st[k] = 1'b1; fn[k] = tf[i]; xs[k] = tx[i]; ys[k] = ty[i];
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) st[k] = 1'b0;
            repeat (3) @(negedge clk);
        end
        st[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            fn[2] = sf[i]; xs[2] = sx[i]; ys[2] = sy[i];
            @(negedge clk);
        end
        st[2] = 1'b0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
